// File: rtl/hc74_dual_dff_if.sv
// Pin bundle of the dual D flip-flop: per-channel preset/clear/strobe/data in, Q/Q_N out.
// Pure wiring, no latency of its own.
// No backpressure; the pins are plain levels.
interface hc74_dual_dff_if;
    logic S1;
    logic R1;
    logic Clk1;
    logic D1;
    logic S2;
    logic R2;
    logic Clk2;
    logic D2;
    logic Q1;
    logic Q1_N;
    logic Q2;
    logic Q2_N;

    // Driver side (board / bench): owns the channel inputs, observes the outputs.
    modport master (
        output S1, R1, Clk1, D1, S2, R2, Clk2, D2,
        input  Q1, Q1_N, Q2, Q2_N
    );

    // Flip-flop side.
    modport slave (
        input  S1, R1, Clk1, D1, S2, R2, Clk2, D2,
        output Q1, Q1_N, Q2, Q2_N
    );
endinterface

// File: rtl/hc74_dual_dff.sv
// 74HC74 dual D flip-flop emulated on one system clock; channel strobes are edge-detected levels.
// Latency: pin change to Q/Q_N is SYNC_STAGES+1 Clk cycles (S, R and strobe edges alike).
// No backpressure; every input is sampled every Clk cycle.
module hc74_dual_dff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst_N,
    hc74_dual_dff_if.slave bus
);

    logic [1:0] s_pin;
    logic [1:0] r_pin;
    logic [1:0] c_pin;
    logic [1:0] d_pin;
    logic [1:0] q_vec;
    logic [1:0] qn_vec;

    assign s_pin = {bus.S2,   bus.S1};
    assign r_pin = {bus.R2,   bus.R1};
    assign c_pin = {bus.Clk2, bus.Clk1};
    assign d_pin = {bus.D2,   bus.D1};

    assign bus.Q1   = q_vec[0];
    assign bus.Q1_N = qn_vec[0];
    assign bus.Q2   = q_vec[1];
    assign bus.Q2_N = qn_vec[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        // Bit 0 is the first stage; the top bit is the synchronized value.
        logic [SYNC_STAGES-1:0] s_sync_q;
        logic [SYNC_STAGES-1:0] r_sync_q;
        logic [SYNC_STAGES-1:0] c_sync_q;
        logic [SYNC_STAGES-1:0] d_sync_q;
        logic                   s_s;
        logic                   r_s;
        logic                   c_s;
        logic                   d_s;
        logic                   cap_edge;
        logic                   prev_q;
        logic                   st_q;
        logic                   st_d;
        logic                   q_q;
        logic                   q_d;
        logic                   qn_q;
        logic                   qn_d;

        assign s_s = s_sync_q[SYNC_STAGES-1];
        assign r_s = r_sync_q[SYNC_STAGES-1];
        assign c_s = c_sync_q[SYNC_STAGES-1];
        assign d_s = d_sync_q[SYNC_STAGES-1];

        // prev_q resets high so a strobe that is still high from before reset is not an edge.
        assign cap_edge = c_s & ~prev_q;

        // Equal-length chains keep S, R, strobe and D aligned; S/R reset to their inactive level.
        always_ff @(posedge Clk) begin
            if (!Rst_N) begin
                s_sync_q <= '1;
                r_sync_q <= '1;
                c_sync_q <= '0;
                d_sync_q <= '0;
            end else begin
                s_sync_q <= (s_sync_q << 1) | SYNC_STAGES'(s_pin[ch]);
                r_sync_q <= (r_sync_q << 1) | SYNC_STAGES'(r_pin[ch]);
                c_sync_q <= (c_sync_q << 1) | SYNC_STAGES'(c_pin[ch]);
                d_sync_q <= (d_sync_q << 1) | SYNC_STAGES'(d_pin[ch]);
            end
        end

        // Preset/clear are levels and win over strobes; a strobe seen while either is active is dropped.
        always_comb begin
            st_d = st_q;
            q_d  = st_q;
            qn_d = ~st_q;
            if (!s_s && !r_s) begin
                st_d = 1'b1;
                q_d  = 1'b1;
                qn_d = 1'b1;
            end else if (!s_s) begin
                st_d = 1'b1;
                q_d  = 1'b1;
                qn_d = 1'b0;
            end else if (!r_s) begin
                st_d = 1'b0;
                q_d  = 1'b0;
                qn_d = 1'b1;
            end else if (cap_edge) begin
                st_d = d_s;
                q_d  = d_s;
                qn_d = ~d_s;
            end
        end

        // Stored bit, registered outputs and strobe history; prev_q advances every cycle so ignored edges are consumed.
        always_ff @(posedge Clk) begin
            if (!Rst_N) begin
                prev_q <= 1'b1;
                st_q   <= 1'b0;
                q_q    <= 1'b0;
                qn_q   <= 1'b1;
            end else begin
                prev_q <= c_s;
                st_q   <= st_d;
                q_q    <= q_d;
                qn_q   <= qn_d;
            end
        end

        assign q_vec[ch]  = q_q;
        assign qn_vec[ch] = qn_q;
    end

endmodule

// File: tb/tb_hc74_dual_dff.sv
// Bench for hc74_dual_dff: directed scenarios plus randomized pins against a pin-history reference model.
// Model output at system edge k is derived from pins sampled at edge k-SYNC.
// No backpressure involved.
module tb_hc74_dual_dff;

    localparam int SYNC = 2;
    localparam int MAXC = 2048;

    typedef struct packed {
        logic s;
        logic r;
        logic c;
        logic d;
    } pin_t;

    localparam pin_t PIN_RST = '{s: 1'b1, r: 1'b1, c: 1'b0, d: 1'b0};

    logic Clk = 1'b0;
    logic Rst_N = 1'b0;

    hc74_dual_dff_if bus();

    hc74_dual_dff #(.SYNC_STAGES(SYNC)) dut (
        .Clk   (Clk),
        .Rst_N (Rst_N),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Pins as seen at each system edge; reset overwrites the slots still inside the synchronizer.
    pin_t hist [2][MAXC];
    int   cyc = 0;
    logic m_q    [2];
    logic m_qn   [2];
    logic m_st   [2];
    logic m_prev [2];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic pin_t pins_of(input int ch);
        pin_t p;
        if (ch == 0) p = '{s: bus.S1, r: bus.R1, c: bus.Clk1, d: bus.D1};
        else         p = '{s: bus.S2, r: bus.R2, c: bus.Clk2, d: bus.D2};
        return p;
    endfunction

    // Advance one system clock: update the model at the edge, compare at the falling edge.
    task automatic step();
        pin_t e;
        logic edge_seen;
        @(posedge Clk);
        for (int ch = 0; ch < 2; ch++) begin
            hist[ch][cyc] = pins_of(ch);
            if (!Rst_N) begin
                for (int j = 0; j < SYNC; j++)
                    if (cyc - j >= 0) hist[ch][cyc - j] = PIN_RST;
                m_q[ch] = 1'b0; m_qn[ch] = 1'b1; m_st[ch] = 1'b0; m_prev[ch] = 1'b1;
            end else begin
                e = (cyc - SYNC >= 0) ? hist[ch][cyc - SYNC] : PIN_RST;
                edge_seen = e.c && !m_prev[ch];
                m_prev[ch] = e.c;
                if (!e.s && !e.r) begin
                    m_st[ch] = 1'b1; m_q[ch] = 1'b1; m_qn[ch] = 1'b1;
                end else if (!e.s) begin
                    m_st[ch] = 1'b1; m_q[ch] = 1'b1; m_qn[ch] = 1'b0;
                end else if (!e.r) begin
                    m_st[ch] = 1'b0; m_q[ch] = 1'b0; m_qn[ch] = 1'b1;
                end else if (edge_seen) begin
                    m_st[ch] = e.d; m_q[ch] = e.d; m_qn[ch] = ~e.d;
                end else begin
                    m_q[ch] = m_st[ch]; m_qn[ch] = ~m_st[ch];
                end
            end
        end
        cyc++;
        @(negedge Clk);
        check("model_ch1", {6'd0, bus.Q1, bus.Q1_N}, {6'd0, m_q[0], m_qn[0]});
        check("model_ch2", {6'd0, bus.Q2, bus.Q2_N}, {6'd0, m_q[1], m_qn[1]});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int ch = 0; ch < 2; ch++) begin
            m_q[ch] = 1'b0; m_qn[ch] = 1'b1; m_st[ch] = 1'b0; m_prev[ch] = 1'b1;
        end
        bus.S1 = 1'b0; bus.R1 = 1'b0; bus.Clk1 = 1'b0; bus.D1 = 1'b0;
        bus.S2 = 1'b0; bus.R2 = 1'b0; bus.Clk2 = 1'b0; bus.D2 = 1'b0;
        Rst_N = 1'b0;
        @(negedge Clk);

        // Reset with S=R=0 and a toggling strobe: outputs stay cleared.
        for (int i = 0; i < 3; i++) begin
            bus.Clk1 = ~bus.Clk1;
            step();
            check("rst_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h01);
            check("rst_q2", {6'd0, bus.Q2, bus.Q2_N}, 8'h01);
        end

        // Release with strobe high and D low: Q1 remains cleared.
        Rst_N = 1'b1;
        bus.S1 = 1'b1; bus.R1 = 1'b1; bus.S2 = 1'b1; bus.R2 = 1'b1;
        steps(4);
        check("post_rst_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h01);

        // Capture D=1 on both channels; exact three-cycle latency.
        bus.Clk1 = 1'b0;
        step();
        bus.D1 = 1'b1; bus.Clk1 = 1'b1;
        bus.D2 = 1'b1; bus.Clk2 = 1'b1;
        steps(2);
        check("lat_before_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h01);
        step();
        check("cap1_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h02);
        check("cap1_q2", {6'd0, bus.Q2, bus.Q2_N}, 8'h02);

        // Capture D=0.
        bus.Clk1 = 1'b0;
        step();
        bus.D1 = 1'b0; bus.Clk1 = 1'b1;
        steps(3);
        check("cap0_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h01);

        // Preset held for 5 cycles while the strobe pulses with D=0.
        bus.S1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.Clk1 = ~bus.Clk1;
            step();
            if (i >= 2) check("preset_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h02);
        end
        bus.S1 = 1'b1;
        steps(4);
        check("preset_rel_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h02);

        // Preset and clear together, then released together with no strobe.
        bus.S1 = 1'b0; bus.R1 = 1'b0;
        steps(3);
        check("both_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h03);
        bus.S1 = 1'b1; bus.R1 = 1'b1;
        steps(3);
        check("both_rel_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h02);

        // Clear Q1 by capture, then clock both channels while R2 is held.
        bus.Clk2 = 1'b0; bus.D1 = 1'b0;
        step();
        bus.Clk1 = 1'b1;
        steps(3);
        check("indep_pre_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h01);
        bus.Clk1 = 1'b0; bus.R2 = 1'b0;
        step();
        bus.D1 = 1'b1; bus.Clk1 = 1'b1;
        bus.D2 = 1'b1; bus.Clk2 = 1'b1;
        steps(3);
        check("indep_q1", {6'd0, bus.Q1, bus.Q1_N}, 8'h02);
        check("indep_q2", {6'd0, bus.Q2, bus.Q2_N}, 8'h01);
        bus.R2 = 1'b1;
        steps(3);

        // Randomized pins: S/R/D every two cycles, strobes at differing rates, one mid-run reset.
        for (int i = 0; i < 240; i++) begin
            if (i % 2 == 0) begin
                bus.S1 = ($urandom % 5) != 0;
                bus.R1 = ($urandom % 5) != 0;
                bus.D1 = 1'($urandom);
                bus.S2 = ($urandom % 5) != 0;
                bus.R2 = ($urandom % 5) != 0;
                bus.D2 = 1'($urandom);
            end
            bus.Clk1 = ~bus.Clk1;
            if (i % 2 == 0) bus.Clk2 = ~bus.Clk2;
            Rst_N = !(i >= 150 && i < 152);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
